// File: rtl/rv_rf_mp.sv
// Multi-port integer register file with per-register busy scoreboard,
// optional write-to-read bypass and hardwired zero register.
module rv_rf_mp #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_reg_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_reg_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_reg_i
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;

  // Per-register view (x[0]..x[NREG-1]) for waveforms; the read path uses it too.
  logic [XLEN-1:0] x [NREG];
  assign x = regs_q;

  // Writes applied in ascending port order so the highest port wins.
  always_comb begin
    logic [AW-1:0] widx;
    widx   = '0;
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned q = 0; q < NWR; q++) begin
      if (wr_en_i[q]) begin
        widx         = wr_reg_i[q*AW +: AW];
        busy_d[widx] = 1'b0;
        if (!(ZERO_REG != 0 && widx == '0)) begin
          regs_d[widx] = wr_data_i[q*XLEN +: XLEN];
        end
      end
    end
    if (sb_set_i && !(ZERO_REG != 0 && sb_reg_i == '0)) begin
      busy_d[sb_reg_i] = 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0]   ridx;
    logic [XLEN-1:0] rval;
    ridx      = '0;
    rval      = '0;
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (rd_en_i[p]) begin
        ridx = rd_reg_i[p*AW +: AW];
        rval = x[ridx];
        if (BYPASS != 0) begin
          for (int unsigned q = 0; q < NWR; q++) begin
            if (wr_en_i[q] && wr_reg_i[q*AW +: AW] == ridx) begin
              rval = wr_data_i[q*XLEN +: XLEN];
            end
          end
        end
        if (ZERO_REG != 0 && ridx == '0) begin
          rval = '0;
        end
        rd_data_d[p*XLEN +: XLEN] = rval;
        rd_busy_d[p]              = busy_d[ridx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule

// File: tb/tb_rv_rf_mp.sv
// Bench for rv_rf_mp: directed steps then random traffic, checked against an
// array-based reference model; BYPASS=1 and BYPASS=0 instances share stimulus.
module tb_rv_rf_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic         clk;
  logic         rst;
  logic [1:0]   rd_en;
  logic [9:0]   rd_reg;
  logic [1:0]   wr_en;
  logic [9:0]   wr_reg;
  logic [127:0] wr_data;
  logic         sb_set;
  logic [4:0]   sb_reg;

  logic [127:0] dut_data, nb_data;
  logic [1:0]   dut_busy, nb_busy;

  logic [63:0]  mreg [32];
  logic [31:0]  mbusy;
  logic [127:0] exp_data, exp_data_nb;
  logic [1:0]   exp_busy;

  int checks = 0;
  int errors = 0;

  rv_rf_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en), .rd_reg_i(rd_reg), .rd_data_o(dut_data), .rd_busy_o(dut_busy),
    .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_reg_i(sb_reg)
  );

  rv_rf_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en), .rd_reg_i(rd_reg), .rd_data_o(nb_data), .rd_busy_o(nb_busy),
    .wr_en_i(wr_en), .wr_reg_i(wr_reg), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_reg_i(sb_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("rd_data",    dut_data, exp_data);
    chk("rd_busy",    {126'd0, dut_busy}, {126'd0, exp_busy});
    chk("rd_data_nb", nb_data, exp_data_nb);
    chk("rd_busy_nb", {126'd0, nb_busy}, {126'd0, exp_busy});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mbusy       = '0;
    exp_data    = '0;
    exp_data_nb = '0;
    exp_busy    = '0;
  endtask

  task automatic model_edge();
    logic [63:0] nreg [32];
    logic [31:0] nbusy;
    logic [4:0]  r;
    logic [63:0] byp;
    nreg  = mreg;
    nbusy = mbusy;
    for (int q = 0; q < 2; q++) begin
      if (wr_en[q]) begin
        r        = wr_reg[q*AW +: AW];
        nbusy[r] = 1'b0;
        if (r != 0) nreg[r] = wr_data[q*XLEN +: XLEN];
      end
    end
    if (sb_set && sb_reg != 0) nbusy[sb_reg] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        r   = rd_reg[p*AW +: AW];
        byp = mreg[r];
        for (int q = 0; q < 2; q++)
          if (wr_en[q] && wr_reg[q*AW +: AW] == r) byp = wr_data[q*XLEN +: XLEN];
        exp_data[p*XLEN +: XLEN]    = (r == 0) ? 64'd0 : byp;
        exp_data_nb[p*XLEN +: XLEN] = (r == 0) ? 64'd0 : mreg[r];
        exp_busy[p]                 = nbusy[r];
      end
    end
    mreg  = nreg;
    mbusy = nbusy;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rd_en = '0; rd_reg = '0; wr_en = '0; wr_reg = '0; wr_data = '0;
    sb_set = 1'b0; sb_reg = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] r);
    rd_en[p] = 1'b1;
    rd_reg[p*AW +: AW] = r;
  endtask

  task automatic set_wr(input int q, input logic [4:0] r, input logic [63:0] d);
    wr_en[q] = 1'b1;
    wr_reg[q*AW +: AW] = r;
    wr_data[q*XLEN +: XLEN] = d;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state seen on every register from both ports
    for (int r = 0; r < 32; r++) begin
      idle(); set_rd(0, 5'(r)); set_rd(1, 5'(31 - r)); cycle();
      chk("reset_data", dut_data, 128'd0);
      chk("reset_busy", {126'd0, dut_busy}, 128'd0);
    end

    // Write then read
    idle(); set_wr(0, 5, 64'hDEAD_BEEF); cycle();
    idle(); set_rd(0, 5); cycle();
    chk("wr_rd_x5", {64'd0, dut_data[63:0]}, {64'd0, 64'hDEAD_BEEF});

    // Same-cycle bypass vs old data
    idle(); set_wr(1, 7, 64'h1234); set_rd(1, 7); cycle();
    chk("bypass_x7",    {64'd0, dut_data[127:64]}, {64'd0, 64'h1234});
    chk("no_bypass_x7", {64'd0, nb_data[127:64]},  128'd0);

    // Port conflict: port 1 wins
    idle(); set_wr(0, 3, 64'hAA); set_wr(1, 3, 64'hBB); cycle();
    idle(); set_rd(0, 3); cycle();
    chk("conflict_x3", {64'd0, dut_data[63:0]}, {64'd0, 64'hBB});

    // Zero register
    idle(); set_wr(0, 0, 64'hFFFF); sb_set = 1'b1; sb_reg = 0; set_rd(1, 0); cycle();
    idle(); set_rd(0, 0); set_rd(1, 0); cycle();
    chk("zero_data", dut_data, 128'd0);
    chk("zero_busy", {126'd0, dut_busy}, 128'd0);

    // Scoreboard
    idle(); sb_set = 1'b1; sb_reg = 9; set_rd(0, 9); cycle();
    chk("sb_set_x9", {127'd0, dut_busy[0]}, 128'd1);
    idle(); sb_set = 1'b1; sb_reg = 9; set_wr(0, 9, 64'h55); set_rd(0, 9); cycle();
    chk("sb_set_wins", {127'd0, dut_busy[0]}, 128'd1);
    idle(); set_wr(1, 9, 64'h66); set_rd(0, 9); cycle();
    chk("sb_clear_x9", {127'd0, dut_busy[0]}, 128'd0);
    idle(); sb_set = 1'b1; sb_reg = 9; set_rd(1, 9); cycle();
    idle(); set_wr(0, 12, 64'h77); sb_set = 1'b1; sb_reg = 12;
    async_reset();
    idle(); set_rd(0, 9); set_rd(1, 12); cycle();
    chk("rst_busy", {126'd0, dut_busy}, 128'd0);
    chk("rst_data", dut_data, 128'd0);

    // Random traffic over a narrow index range to provoke collisions
    for (int i = 0; i < 600; i++) begin
      idle();
      rd_en   = 2'($urandom_range(0, 3));
      rd_reg  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      wr_en   = 2'($urandom_range(0, 3));
      wr_reg  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      sb_set  = 1'($urandom_range(0, 1));
      sb_reg  = 5'($urandom_range(0, 11));
      if ($urandom_range(0, 79) == 0) async_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
